alu_ex_stage: RTL and testbench
===============================

# alu_ex_stage

Execute-stage front end that drives the combinational `alu` instance in the in-order core. It accepts decoded ALU uops from decode over a valid/ready handshake and presents `alu_op1`, `alu_op2` and `alu_func` to the ALU from a registered operand stage. It captures `alu_out` into a result register and hands the result, with its destination tag, to writeback over a second valid/ready handshake. Full throughput is one uop per cycle; backpressure propagates cleanly from writeback to decode.

## Interface
- `WIDTH`, 32: operand and result width.
- `RD_W`, 5: destination register tag width.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `flush` input 1: synchronous pipeline kill.
- `id_valid` input 1: decode uop valid.
- `id_ready` output 1: stage can accept a uop this cycle.
- `id_op1`, `id_op2` input WIDTH: operands.
- `id_alu_func` input 4: `alu_func` code from `alu_pkg`.
- `id_rd` input RD_W: destination tag.
- `alu_op1`, `alu_op2` output WIDTH: drive the ALU.
- `alu_func` output 4: drives the ALU.
- `alu_out` input WIDTH: ALU result, combinational from the three ports above.
- `wb_valid` output 1: result valid.
- `wb_ready` input 1: writeback accepts.
- `wb_data` output WIDTH: result.
- `wb_rd` output RD_W: destination tag.
- `wb_illegal` output 1: uop carried an undefined func code.
- `perf_ops` output 32: completed writeback handshakes.
- `perf_stall` output 32: cycles with `wb_valid && !wb_ready`.

## Operation
- Two stages:
  - **A** holds operands, func, rd and `a_valid`.
  - **B** holds data, rd, illegal flag and `b_valid`.
- The ALU ports are driven directly from the A registers, independent of `a_valid`.
- Control signals:
  - `b_free = !b_valid || wb_ready`
  - `a_adv = a_valid && b_free`
  - `id_ready = !flush && (!a_valid || b_free)`
- Accept:
  - When `id_valid && id_ready`, A loads the uop and `a_valid` becomes 1.
  - Otherwise, on `a_adv`, `a_valid` becomes 0.
  - A's data registers hold their value when A is not loaded.
- Advance:
  - On `a_adv`, B loads `alu_out` and `a_rd`, and `b_valid` becomes 1.
  - Otherwise, on a writeback handshake, `b_valid` becomes 0.
- Legal func codes are 0–10. Codes 11–15 are illegal:
  - B captures data 0 and sets `wb_illegal`.
  - The uop still flows and completes normally.
- Width rule: results are `WIDTH` bits, truncated with no carry-out. Shift amounts use `alu_op2[4:0]`, which is the ALU's concern.
- `perf_ops` increments on each `wb_valid && wb_ready`.
- `perf_stall` increments on each `wb_valid && !wb_ready`.
- Both counters wrap from 0xFFFF_FFFF to 0.
- Flush:
  - Clears `a_valid` and `b_valid` at the next edge.
  - `id_ready` is 0 during the flush cycle, so no uop is accepted.
  - A writeback handshake in the flush cycle completes and is counted, since it is the oldest op.
  - A and B data registers keep stale values.
- Reset:
  - All valids, all data registers and `wb_illegal` go to 0.
  - `alu_func` output goes to 0 (PASS_B).
  - Both counters go to 0.
  - `id_ready` is 1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight uops; reset overrides flush.

## Timing
- Latency:
  - Uop accepted at edge E0.
  - ALU ports carry it during cycle E0→E1.
  - `wb_valid` is asserted from E1 when B is free at E1.
- Back-to-back: a new uop is accepted every cycle while `wb_ready` stays 1.
- Backpressure:
  - With `wb_ready` held low, B holds and A fills.
  - `id_ready` falls in the cycle after A fills.
  - At most 2 uops are in flight.
- `wb_valid`, `wb_data`, `wb_rd` and `wb_illegal` remain stable while `wb_valid && !wb_ready`.
- `id_ready` depends combinationally on `wb_ready` and `flush`. No other path from input to output is combinational except through the external ALU.

## Structure
- `alu_pkg`:
  - `alu_func_e` 4-bit enum: PASS_B=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10.
  - `ALU_FUNC_MAX` = 10.
  - Packed struct `alu_uop_t` with fields op1, op2, func, rd.
- `alu` is instantiated at the top, not inside this block. This keeps the ALU's SDF-annotated netlist swappable.
- One sub-module: `perf_cnt32`, an enable-driven 32-bit wrapping counter with synchronous reset, instantiated twice.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `id_valid=1`.
  - During reset: `id_ready=0`, `wb_valid=0`, both counters 0, `alu_func=0`.
  - After release: `id_ready=1`.
- **Basic ADD:** `id_op1=1`, `id_op2=2`, func=1, `rd=5`, `wb_ready=1`.
  - Response: `wb_valid` one edge after accept, `wb_data=3`, `wb_rd=5`, `perf_ops=1`.
- **Streaming:** 8 ADDs back-to-back (`op1=i`, `op2=2`) with `wb_ready=1`.
  - Response: 8 consecutive `wb_valid` cycles, `wb_data` = 2..9 in order, `perf_stall=0`.
- **Backpressure:** `wb_ready=0` for 4 cycles during a stream.
  - `id_ready` drops after 2 uops are accepted.
  - `wb_data` is held.
  - `perf_stall=4`.
  - No uop is lost or duplicated when `wb_ready` returns to 1.
- **Flush:** assert `flush` with A and B full and `wb_ready=1`.
  - B's handshake completes and is counted.
  - Both stages are empty next cycle.
  - The uop presented during the flush cycle is not accepted.
- **Illegal code:** func=13, `op1=7`.
  - Response: `wb_illegal=1`, `wb_data=0`, `perf_ops` increments.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, the decoded uop layout and a legality helper.
package alu_pkg;

    typedef enum logic [3:0] {
        PASS_B = 4'd0,
        ADD    = 4'd1,
        SUB    = 4'd2,
        AND    = 4'd3,
        OR     = 4'd4,
        XOR    = 4'd5,
        SLL    = 4'd6,
        SRL    = 4'd7,
        SRA    = 4'd8,
        SLT    = 4'd9,
        SLTU   = 4'd10
    } alu_func_e;

    localparam logic [3:0] ALU_FUNC_MAX = 4'd10;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  func;
        logic [4:0]  rd;
    } alu_uop_t;

    function automatic logic is_legal_func(input logic [3:0] func);
        return func <= ALU_FUNC_MAX;
    endfunction

endpackage

// File: rtl/perf_cnt32.sv
// Free-running 32-bit event counter; wraps to zero after 0xFFFF_FFFF.
module perf_cnt32
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Two-register execute front end: stage A drives the external ALU, stage B holds the
// captured result for writeback. One uop per cycle, at most two in flight.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [WIDTH-1:0] id_op1,
    input  logic [WIDTH-1:0] id_op2,
    input  logic [3:0]       id_alu_func,
    input  logic [RD_W-1:0]  id_rd,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_func,
    input  logic [WIDTH-1:0] alu_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_illegal,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // A producer holds valid and its payload stable until that edge; ready may depend
    // combinationally on downstream ready, valid never depends on ready.
    logic             a_valid;
    logic [WIDTH-1:0] a_op1;
    logic [WIDTH-1:0] a_op2;
    logic [3:0]       a_func;
    logic [RD_W-1:0]  a_rd;

    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic [RD_W-1:0]  b_rd;
    logic             b_illegal;

    logic b_free;
    logic a_adv;
    logic id_fire;
    logic wb_fire;

    assign b_free   = !b_valid || wb_ready;
    assign a_adv    = a_valid && b_free;
    // Reset gating keeps decode from seeing a ready while the pipe is being cleared.
    assign id_ready = !rst && !flush && (!a_valid || b_free);
    assign id_fire  = id_valid && id_ready;
    assign wb_fire  = b_valid && wb_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            a_op1     <= '0;
            a_op2     <= '0;
            a_func    <= PASS_B;
            a_rd      <= '0;
            b_valid   <= 1'b0;
            b_data    <= '0;
            b_rd      <= '0;
            b_illegal <= 1'b0;
        end else begin
            if (flush) begin
                a_valid <= 1'b0;
            end else if (id_fire) begin
                a_valid <= 1'b1;
            end else if (a_adv) begin
                a_valid <= 1'b0;
            end

            if (id_fire) begin
                a_op1  <= id_op1;
                a_op2  <= id_op2;
                a_func <= id_alu_func;
                a_rd   <= id_rd;
            end

            if (flush) begin
                b_valid <= 1'b0;
            end else if (a_adv) begin
                b_valid <= 1'b1;
            end else if (wb_fire) begin
                b_valid <= 1'b0;
            end

            // Undefined codes still complete, but never leak whatever the ALU produced.
            if (a_adv && !flush) begin
                b_data    <= is_legal_func(a_func) ? alu_out : '0;
                b_rd      <= a_rd;
                b_illegal <= !is_legal_func(a_func);
            end
        end
    end

    assign alu_op1    = a_op1;
    assign alu_op2    = a_op2;
    assign alu_func   = a_func;
    assign wb_valid   = b_valid;
    assign wb_data    = b_data;
    assign wb_rd      = b_rd;
    assign wb_illegal = b_illegal;

    perf_cnt32 u_ops_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (wb_fire),
        .count (perf_ops)
    );

    perf_cnt32 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (b_valid && !wb_ready),
        .count (perf_stall)
    );

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage with a behavioural ALU closing the loop on alu_out.
module tb_alu_ex_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_op1;
    logic [31:0] id_op2;
    logic [3:0]  id_alu_func;
    logic [4:0]  id_rd;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_func;
    logic [31:0] alu_out;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_illegal;
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;

    int          checks;
    int          errors;
    logic [31:0] exp_ops;
    logic [31:0] exp_stall;
    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];

    alu_ex_stage #(.WIDTH(32), .RD_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_op1      (id_op1),
        .id_op2      (id_op2),
        .id_alu_func (id_alu_func),
        .id_rd       (id_rd),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_func    (alu_func),
        .alu_out     (alu_out),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_illegal  (wb_illegal),
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall)
    );

    // External combinational ALU; undefined codes produce a poison value.
    always_comb begin
        alu_out = 32'hDEAD_BEEF;
        case (alu_func)
            4'd0:    alu_out = alu_op2;
            4'd1:    alu_out = alu_op1 + alu_op2;
            4'd2:    alu_out = alu_op1 - alu_op2;
            4'd3:    alu_out = alu_op1 & alu_op2;
            4'd4:    alu_out = alu_op1 | alu_op2;
            4'd5:    alu_out = alu_op1 ^ alu_op2;
            4'd6:    alu_out = alu_op1 << alu_op2[4:0];
            4'd7:    alu_out = alu_op1 >> alu_op2[4:0];
            4'd8:    alu_out = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
            4'd9:    alu_out = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
            4'd10:   alu_out = {31'd0, alu_op1 < alu_op2};
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        id_valid = 1'b1;
        id_op1 = 32'h1111_1111;
        id_op2 = 32'h2222_2222;
        id_alu_func = 4'd1;
        id_rd = 5'd3;
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            sample();
            checks++;
            if (id_ready !== 1'b0 || wb_valid !== 1'b0 || alu_func !== 4'd0) begin
                errors++;
                $display("FAIL reset_outputs: id_ready=%b wb_valid=%b alu_func=%0d, required 0 0 0",
                         id_ready, wb_valid, alu_func);
            end
            checks++;
            if (perf_ops !== 32'd0 || perf_stall !== 32'd0) begin
                errors++;
                $display("FAIL reset_counters: ops=%0d stall=%0d, required 0 0", perf_ops, perf_stall);
            end
        end
        cyc();
        rst = 1'b0;
        id_valid = 1'b0;
        sample();
        checks++;
        if (id_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: id_ready=%b wb_valid=%b, required 1 0", id_ready, wb_valid);
        end
        exp_ops = 0;
        exp_stall = 0;
    endtask

    task automatic test_basic_add();
        cyc();
        id_valid = 1'b1;
        id_op1 = 32'd1;
        id_op2 = 32'd2;
        id_alu_func = 4'd1;
        id_rd = 5'd5;
        wb_ready = 1'b1;
        sample();
        checks++;
        if (id_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_ready: id_ready=%b, required 1", id_ready);
        end
        cyc();
        id_valid = 1'b0;
        sample();
        checks++;
        if (alu_op1 !== 32'd1 || alu_op2 !== 32'd2 || alu_func !== 4'd1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_alu_ports: op1=%0d op2=%0d func=%0d wb_valid=%b, required 1 2 1 0",
                     alu_op1, alu_op2, alu_func, wb_valid);
        end
        cyc();
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'd3 || wb_rd !== 5'd5 || wb_illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_result: valid=%b data=%0d rd=%0d ill=%b, required 1 3 5 0",
                     wb_valid, wb_data, wb_rd, wb_illegal);
        end
        exp_ops = exp_ops + 1;
        cyc();
        sample();
        checks++;
        if (perf_ops !== exp_ops || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_done: perf_ops=%0d wb_valid=%b, required %0d 0", perf_ops, wb_valid, exp_ops);
        end
    endtask

    task automatic test_streaming();
        for (int c = 0; c <= 10; c++) begin
            cyc();
            wb_ready = 1'b1;
            if (c < 8) begin
                id_valid = 1'b1;
                id_op1 = c;
                id_op2 = 32'd2;
                id_alu_func = 4'd1;
                id_rd = 5'(c);
            end else begin
                id_valid = 1'b0;
            end
            sample();
            if (c < 8) begin
                checks++;
                if (id_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready c=%0d: id_ready=%b, required 1", c, id_ready);
                end
            end
            if (c >= 2 && c <= 9) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_data !== 32'(c) || wb_rd !== 5'(c - 2)) begin
                    errors++;
                    $display("FAIL stream_data c=%0d: valid=%b data=%0d rd=%0d, required 1 %0d %0d",
                             c, wb_valid, wb_data, wb_rd, c, c - 2);
                end
            end
        end
        exp_ops = exp_ops + 8;
        checks++;
        if (wb_valid !== 1'b0 || perf_ops !== exp_ops || perf_stall !== exp_stall) begin
            errors++;
            $display("FAIL stream_counts: valid=%b ops=%0d stall=%0d, required 0 %0d %0d",
                     wb_valid, perf_ops, perf_stall, exp_ops, exp_stall);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        exp_q.delete();
        exp_rd_q.delete();
        for (int c = 0; c < 16; c++) begin
            cyc();
            wb_ready = !(c >= 2 && c <= 5);
            id_valid = (sent < 6);
            id_op1 = 32'(10 + sent);
            id_op2 = 32'd2;
            id_alu_func = 4'd1;
            id_rd = 5'(20 + sent);
            sample();
            if (c == 3) begin
                checks++;
                if (id_ready !== 1'b0 || sent != 2) begin
                    errors++;
                    $display("FAIL bp_ready_drop: id_ready=%b accepted=%0d, required 0 2", id_ready, sent);
                end
            end
            if (wb_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: data=%0d seen with nothing outstanding", wb_data);
                end else if (wb_data !== exp_q[0] || wb_rd !== exp_rd_q[0]) begin
                    errors++;
                    $display("FAIL bp_data c=%0d: data=%0d rd=%0d, required %0d %0d",
                             c, wb_data, wb_rd, exp_q[0], exp_rd_q[0]);
                end
                if (wb_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_rd_q.pop_front());
                    got++;
                end
            end
            if (id_valid && id_ready) begin
                exp_q.push_back(32'(12 + sent));
                exp_rd_q.push_back(5'(20 + sent));
                sent++;
            end
        end
        id_valid = 1'b0;
        exp_ops = exp_ops + 6;
        exp_stall = exp_stall + 4;
        checks++;
        if (got != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_complete: received=%0d outstanding=%0d, required 6 0", got, exp_q.size());
        end
        checks++;
        if (perf_stall !== exp_stall || perf_ops !== exp_ops) begin
            errors++;
            $display("FAIL bp_counters: stall=%0d ops=%0d, required %0d %0d",
                     perf_stall, perf_ops, exp_stall, exp_ops);
        end
    endtask

    task automatic test_flush();
        cyc();
        wb_ready = 1'b1;
        id_valid = 1'b1;
        id_op1 = 32'd100;
        id_op2 = 32'd2;
        id_alu_func = 4'd1;
        id_rd = 5'd1;
        cyc();
        id_op1 = 32'd200;
        id_rd = 5'd2;
        cyc();
        flush = 1'b1;
        id_op1 = 32'd300;
        id_rd = 5'd3;
        sample();
        checks++;
        if (id_ready !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'd102) begin
            errors++;
            $display("FAIL flush_cycle: id_ready=%b valid=%b data=%0d, required 0 1 102",
                     id_ready, wb_valid, wb_data);
        end
        exp_ops = exp_ops + 1;
        cyc();
        flush = 1'b0;
        id_valid = 1'b0;
        sample();
        checks++;
        if (wb_valid !== 1'b0 || id_ready !== 1'b1 || perf_ops !== exp_ops) begin
            errors++;
            $display("FAIL flush_empty: valid=%b id_ready=%b ops=%0d, required 0 1 %0d",
                     wb_valid, id_ready, perf_ops, exp_ops);
        end
        cyc();
        sample();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: valid=%b data=%0d, required valid 0", wb_valid, wb_data);
        end
    endtask

    task automatic test_illegal();
        cyc();
        wb_ready = 1'b1;
        id_valid = 1'b1;
        id_op1 = 32'd7;
        id_op2 = 32'd3;
        id_alu_func = 4'd13;
        id_rd = 5'd9;
        cyc();
        id_alu_func = 4'd2;
        id_rd = 5'd10;
        sample();
        cyc();
        id_valid = 1'b0;
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_illegal !== 1'b1 || wb_data !== 32'd0 || wb_rd !== 5'd9) begin
            errors++;
            $display("FAIL illegal_result: valid=%b ill=%b data=%0h rd=%0d, required 1 1 0 9",
                     wb_valid, wb_illegal, wb_data, wb_rd);
        end
        cyc();
        sample();
        checks++;
        if (wb_valid !== 1'b1 || wb_illegal !== 1'b0 || wb_data !== 32'd4 || wb_rd !== 5'd10) begin
            errors++;
            $display("FAIL illegal_next_legal: valid=%b ill=%b data=%0d rd=%0d, required 1 0 4 10",
                     wb_valid, wb_illegal, wb_data, wb_rd);
        end
        exp_ops = exp_ops + 2;
        cyc();
        sample();
        checks++;
        if (perf_ops !== exp_ops) begin
            errors++;
            $display("FAIL illegal_counted: ops=%0d, required %0d", perf_ops, exp_ops);
        end
    endtask

    task automatic test_func_mix();
        logic [31:0] v_op1[7] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd1, 32'h1234_5678};
        logic [31:0] v_op2[7] = '{32'd1, 32'd7, 32'd4, 32'd1, 32'd1, 32'd33, 32'h55};
        logic [3:0]  v_fn[7]  = '{4'd1, 4'd2, 4'd8, 4'd10, 4'd9, 4'd6, 4'd0};
        logic [31:0] v_exp[7] = '{32'd0, 32'hFFFF_FFFE, 32'hF800_0000, 32'd0,
                                  32'd1, 32'd2, 32'h55};
        for (int i = 0; i < 7; i++) begin
            cyc();
            wb_ready = 1'b1;
            id_valid = 1'b1;
            id_op1 = v_op1[i];
            id_op2 = v_op2[i];
            id_alu_func = v_fn[i];
            id_rd = 5'(i);
            cyc();
            id_valid = 1'b0;
            cyc();
            sample();
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== v_exp[i] || wb_illegal !== 1'b0) begin
                errors++;
                $display("FAIL func_mix[%0d] fn=%0d: valid=%b data=%0h ill=%b, required 1 %0h 0",
                         i, v_fn[i], wb_valid, wb_data, wb_illegal, v_exp[i]);
            end
            exp_ops = exp_ops + 1;
        end
        cyc();
        sample();
        checks++;
        if (perf_ops !== exp_ops) begin
            errors++;
            $display("FAIL func_mix_ops: ops=%0d, required %0d", perf_ops, exp_ops);
        end
    endtask

    task automatic test_reset_midflight();
        cyc();
        wb_ready = 1'b0;
        id_valid = 1'b1;
        id_op1 = 32'd40;
        id_op2 = 32'd2;
        id_alu_func = 4'd1;
        id_rd = 5'd7;
        cyc();
        id_op1 = 32'd50;
        cyc();
        rst = 1'b1;
        flush = 1'b1;
        sample();
        checks++;
        if (id_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: id_ready=%b, required 0", id_ready);
        end
        cyc();
        rst = 1'b0;
        flush = 1'b0;
        id_valid = 1'b0;
        wb_ready = 1'b1;
        sample();
        checks++;
        if (wb_valid !== 1'b0 || id_ready !== 1'b1 || alu_func !== 4'd0 ||
            perf_ops !== 32'd0 || perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL midrst_state: valid=%b id_ready=%b func=%0d ops=%0d stall=%0d, required 0 1 0 0 0",
                     wb_valid, id_ready, alu_func, perf_ops, perf_stall);
        end
        cyc();
        sample();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_ghost: valid=%b, required 0", wb_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_ops = 0;
        exp_stall = 0;
        test_reset();
        test_basic_add();
        test_streaming();
        test_backpressure();
        test_flush();
        test_illegal();
        test_func_mix();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
